// File: rtl/adcsum_window_ctrl_if.sv
// Result readout bus from the acquisition window controller to the pulse-sequencer readout path.
// Latency: none, plain wires.
// Backpressure: result_valid/result_ready handshake. Data is held stable while valid is high and not yet taken.
// Ports: result_sum, result_count, result_valid (master drives), result_ready (slave drives).
interface adcsum_window_ctrl_if #(
  parameter int SUM_WIDTH   = 32,
  parameter int COUNT_WIDTH = 16
);
  logic [SUM_WIDTH-1:0]   result_sum;
  logic [COUNT_WIDTH-1:0] result_count;
  logic                   result_valid;
  logic                   result_ready;

  modport master (
    output result_sum,
    output result_count,
    output result_valid,
    input  result_ready
  );

  modport slave (
    input  result_sum,
    input  result_count,
    input  result_valid,
    output result_ready
  );
endinterface

// File: rtl/adcsum_window_ctrl.sv
// Sequences an ADC accumulator core over one acquisition window and captures sum/count into a one-deep result register.
// Latency: start to first accumulated strobe is 2 clocks; last strobe to result_valid is ACC_LATENCY+2 clocks.
// Backpressure: a window that completes while the previous result is still unread is dropped and sets sticky overrun.
// Ports: clk/sclr_n (sync active-low reset), start/stop/sample_limit control, adc_ready strobe in,
//        acc_ce/acc_sclr out to the core, acc_q/acc_count back from the core, res result bus (master), busy, overrun.
module adcsum_window_ctrl #(
  parameter int SUM_WIDTH   = 32,
  parameter int COUNT_WIDTH = 16,
  parameter int ACC_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   sclr_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [COUNT_WIDTH-1:0] sample_limit,
  input  logic                   adc_ready,
  output logic                   acc_ce,
  output logic                   acc_sclr,
  input  logic [SUM_WIDTH-1:0]   acc_q,
  input  logic [COUNT_WIDTH-1:0] acc_count,
  adcsum_window_ctrl_if.master   res,
  output logic                   busy,
  output logic                   overrun
);

  localparam int DW = (ACC_LATENCY > 1) ? $clog2(ACC_LATENCY) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    ACCUM   = 3'd2,
    DRAIN   = 3'd3,
    CAPTURE = 3'd4
  } state_t;

  state_t                 state;
  logic [COUNT_WIDTH-1:0] lim;
  logic [COUNT_WIDTH-1:0] smp_cnt;
  logic [COUNT_WIDTH-1:0] smp_nxt;
  logic [DW-1:0]          drain_cnt;
  logic                   last_strobe;
  logic                   drain_done;

  // Gating is combinational so a strobe reaches the core in the same cycle it arrives.
  // A strobe that coincides with stop is deliberately dropped. Reset forces the gate closed.
  assign acc_ce  = sclr_n & (state == ACCUM) & adc_ready & ~stop;
  assign busy    = (state != IDLE);
  assign smp_nxt = smp_cnt + COUNT_WIDTH'(1);

  // The strobe being accepted now is the last one: it either reaches the latched limit
  // or fills the counter. The all-ones guard keeps the core count from ever wrapping.
  assign last_strobe = ((lim != '0) && (smp_nxt == lim)) || (smp_nxt == '1);
  assign drain_done  = (drain_cnt == DW'(ACC_LATENCY - 1));

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      state            <= IDLE;
      acc_sclr         <= 1'b1;
      lim              <= '0;
      smp_cnt          <= '0;
      drain_cnt        <= '0;
      overrun          <= 1'b0;
      res.result_valid <= 1'b0;
      res.result_sum   <= '0;
      res.result_count <= '0;
    end else begin
      acc_sclr <= 1'b0;

      // The consumer taking the result drops valid. A CAPTURE in this same cycle
      // overrides this further down and keeps valid high with the new data.
      if (res.result_valid && res.result_ready) begin
        res.result_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            lim      <= sample_limit;
            smp_cnt  <= '0;
            acc_sclr <= 1'b1;
            state    <= CLEAR;
          end
        end

        CLEAR: begin
          state <= ACCUM;
        end

        ACCUM: begin
          drain_cnt <= '0;
          if (stop) begin
            state <= DRAIN;
          end else if (adc_ready) begin
            smp_cnt <= smp_nxt;
            if (last_strobe) begin
              state <= DRAIN;
            end
          end
        end

        // Let the core pipeline settle before sampling acc_q/acc_count.
        DRAIN: begin
          if (drain_done) begin
            state <= CAPTURE;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end

        CAPTURE: begin
          if (!res.result_valid || res.result_ready) begin
            res.result_sum   <= acc_q;
            res.result_count <= acc_count;
            res.result_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
